// File: rtl/eth_pkg.sv
// Shared types and timing constants for the 10BASE-T transmit scheduler.
// Defaults assume a 20 MHz system clock.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_SEND      = 3'd3,
        ST_IFG       = 3'd4,
        ST_NLP       = 3'd5
    } state_e;

    localparam int CLK_HZ         = 20_000_000;
    localparam int BIT_RATE       = 10_000_000;
    localparam int IFG_BIT_TIMES  = 96;
    localparam int NLP_MS         = 16;
    localparam int NLP_WIDTH_NS   = 100;

    localparam int IFG_CYCLES_DEF = (CLK_HZ / BIT_RATE) * IFG_BIT_TIMES;
    localparam int NLP_PERIOD_DEF = (CLK_HZ / 1000) * NLP_MS;
    localparam int NLP_WIDTH_DEF  = (NLP_WIDTH_NS * (CLK_HZ / 1_000_000)) / 1000;
    localparam int START_TO_DEF   = 16;
    localparam int CNT_W_DEF      = 19;

    localparam int N_REQ          = 2;

endpackage

// File: rtl/eth_tx_sched_if.sv
// Requester/transmitter handshake bundle between the scheduler and its environment.
interface eth_tx_sched_if;
    import eth_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] grant;
    logic             sel;
    logic             transmit;
    logic             tx_busy;
    logic             frame_done;
    logic             err_timeout;

    modport master (
        input  req,
        input  tx_busy,
        output transmit,
        output grant,
        output sel,
        output frame_done,
        output err_timeout
    );

    modport slave (
        output req,
        output tx_busy,
        input  transmit,
        input  grant,
        input  sel,
        input  frame_done,
        input  err_timeout
    );

endinterface

// File: rtl/eth_rr_arb2.sv
// Two-way round-robin arbiter: combinational winner, registered last-grant pointer.
// Until the first grant after reset requester 0 is preferred.
module eth_rr_arb2
    import eth_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             upd,
    input  logic             upd_idx,
    output logic             win
);

    logic last_q;
    logic last_d;
    logic hist_q;
    logic hist_d;

    // Winner selection from the current requests and grant history
    always_comb begin
        win = 1'b0;
        case (req)
            2'b11:   win = hist_q ? ~last_q : 1'b0;
            2'b10:   win = 1'b1;
            2'b01:   win = 1'b0;
            default: win = 1'b0;
        endcase
    end

    // Pointer update when a grant is issued
    always_comb begin
        last_d = last_q;
        hist_d = hist_q;
        if (upd) begin
            last_d = upd_idx;
            hist_d = 1'b1;
        end else begin
            last_d = last_q;
            hist_d = hist_q;
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            last_q <= last_d;
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// Transmit scheduler for eth_frame: round-robin frame start, busy tracking,
// inter-frame gap and idle-link NLP generation on one shared down-counter.
module eth_tx_sched
    import eth_pkg::*;
#(
    parameter int IFG_CYCLES    = IFG_CYCLES_DEF,
    parameter int NLP_PERIOD    = NLP_PERIOD_DEF,
    parameter int NLP_WIDTH     = NLP_WIDTH_DEF,
    parameter int START_TIMEOUT = START_TO_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           link_en,
    output logic           nlp,
    eth_tx_sched_if.master bus
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - longint'(1);

    function automatic logic [CNT_W-1:0] sat_ld(input longint v);
        logic [CNT_W-1:0] r;
        if (v > CNT_MAX) begin
            r = {CNT_W{1'b1}};
        end else if (v < longint'(0)) begin
            r = {CNT_W{1'b0}};
        end else begin
            r = v[CNT_W-1:0];
        end
        return r;
    endfunction

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] NLP_LD   = sat_ld(longint'(NLP_PERIOD));
    localparam logic [CNT_W-1:0] NLP_W_LD = sat_ld(longint'(NLP_WIDTH) - longint'(1));
    // Registered err_timeout then lands exactly START_TIMEOUT cycles after transmit
    localparam logic [CNT_W-1:0] TO_LD    = sat_ld(longint'(START_TIMEOUT) - longint'(1));
    localparam logic [CNT_W-1:0] IFG_LD   = sat_ld(longint'(IFG_CYCLES) - longint'(1));

    if ((longint'(IFG_CYCLES) > CNT_MAX) || (longint'(NLP_PERIOD) > CNT_MAX) ||
        (longint'(START_TIMEOUT) > CNT_MAX)) begin : g_cnt_w_chk
        $error("eth_tx_sched: CNT_W too narrow for IFG_CYCLES/NLP_PERIOD/START_TIMEOUT");
    end

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sel_q;
    logic             sel_d;
    logic             transmit_q;
    logic             transmit_d;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] grant_d;
    logic             nlp_q;
    logic             nlp_d;
    logic             frame_done_q;
    logic             frame_done_d;
    logic             err_timeout_q;
    logic             err_timeout_d;
    logic             arb_upd;
    logic             arb_win;

    assign arb_upd = (state_q == ST_START);

    eth_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req),
        .upd     (arb_upd),
        .upd_idx (sel_q),
        .win     (arb_win)
    );

    // Next-state, shared counter and next output values
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sel_d         = sel_q;
        frame_done_d  = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    sel_d   = arb_win;
                    state_d = ST_START;
                end else if (link_en) begin
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = NLP_W_LD;
                        state_d = ST_NLP;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_START: begin
                cnt_d   = TO_LD;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = ST_SEND;
                end else if (cnt_q <= CNT_ONE) begin
                    err_timeout_d = 1'b1;
                    cnt_d         = IFG_LD;
                    state_d       = ST_IFG;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_SEND: begin
                if (!bus.tx_busy) begin
                    frame_done_d = 1'b1;
                    cnt_d        = IFG_LD;
                    state_d      = ST_IFG;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_IFG, ST_NLP: begin
                if (cnt_q == CNT_ZERO) begin
                    cnt_d   = NLP_LD;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                cnt_d   = NLP_LD;
                state_d = ST_IDLE;
            end
        endcase

        transmit_d = (state_d == ST_START);
        nlp_d      = (state_d == ST_NLP);
        if (state_d == ST_START) begin
            grant_d = sel_d ? 2'b10 : 2'b01;
        end else begin
            grant_d = {N_REQ{1'b0}};
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= NLP_LD;
            sel_q         <= 1'b0;
            transmit_q    <= 1'b0;
            grant_q       <= {N_REQ{1'b0}};
            nlp_q         <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            transmit_q    <= transmit_d;
            grant_q       <= grant_d;
            nlp_q         <= nlp_d;
            frame_done_q  <= frame_done_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.transmit    = transmit_q;
    assign bus.grant       = grant_q;
    assign bus.sel         = sel_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.err_timeout = err_timeout_q;
    assign nlp             = nlp_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched with a simple eth_frame busy model
// (busy rises 1 cycle after transmit and stays high 20 cycles).
module tb_eth_tx_sched;
    import eth_pkg::*;

    localparam int W_TX = 0, W_FD = 1, W_ERR = 2, W_NLP = 3, W_IDLE = 4;

    logic clk = 1'b0;
    logic rst;
    logic link_en;
    logic nlp;

    eth_tx_sched_if bus ();

    eth_tx_sched #(
        .IFG_CYCLES    (8),
        .NLP_PERIOD    (40),
        .NLP_WIDTH     (2),
        .START_TIMEOUT (4),
        .CNT_W         (19)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .link_en (link_en),
        .nlp     (nlp),
        .bus     (bus)
    );

    always #25 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit model_en;
    int busy_left = 0;

    // eth_frame stand-in
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            busy_left   = 0;
            bus.tx_busy = 1'b0;
        end else begin
            if (busy_left > 0) begin
                bus.tx_busy = 1'b1;
                busy_left--;
            end else begin
                bus.tx_busy = 1'b0;
            end
            if (bus.transmit === 1'b1 && model_en) busy_left = 20;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            W_TX:    return bus.transmit;
            W_FD:    return bus.frame_done;
            W_ERR:   return bus.err_timeout;
            W_NLP:   return nlp;
            W_IDLE:  return (dut.state_q == ST_IDLE);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int which, input int lim);
        int i;
        i = 0;
        while (sig_of(which) !== 1'b1 && i < lim) begin
            tick();
            i++;
        end
        chk_eq(tag, sig_of(which), 1'b1);
    endtask

    function automatic logic [6:0] outs();
        return {bus.transmit, bus.grant, bus.sel, nlp, bus.frame_done, bus.err_timeout};
    endfunction

    initial begin
        int t0;
        int t1;
        int cnt_hi;
        logic [1:0] exp_g;

        rst = 1'b1; link_en = 1'b0; bus.req = 2'b00; model_en = 1'b1;
        repeat (3) tick();
        chk_eq("rst_outs", outs(), 7'd0);
        chk_eq("rst_state", dut.state_q, ST_IDLE);

        // 1: single request, frame_done, IFG spacing
        rst = 1'b0;
        tick();
        chk_eq("rel_quiet", outs(), 7'd0);
        bus.req = 2'b01;
        tick();
        chk_eq("t1_tx", bus.transmit, 1'b1);
        chk_eq("t1_grant", bus.grant, 2'b01);
        chk_eq("t1_sel", bus.sel, 1'b0);
        t0 = cyc;
        bus.req = 2'b00;
        tick();
        chk_eq("t1_strobe_1cyc", {bus.transmit, bus.grant}, 3'd0);
        wait_sig("t1_fd", W_FD, 40);
        chk_eq("t1_fd_lat", cyc - t0, 22);
        t1 = cyc;
        bus.req = 2'b01;
        tick();
        chk_eq("t1_fd_1cyc", bus.frame_done, 1'b0);
        wait_sig("t1_tx2", W_TX, 40);
        chk_eq("t1_ifg_gap", cyc - t1, 9);
        bus.req = 2'b00;
        wait_sig("t1_idle", W_IDLE, 60);

        // 2: both requesters from reset, strict alternation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_sig("t2_tx", W_TX, 60);
            chk_eq("t2_grant", bus.grant, exp_g);
            chk_eq("t2_sel", bus.sel, exp_g[1]);
            repeat (10) tick();
            chk_eq("t2_sel_hold", bus.sel, exp_g[1]);
        end
        bus.req = 2'b00;
        wait_sig("t2_idle", W_IDLE, 60);

        // 3: NLP cadence, link_en gating, hold of the counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        link_en = 1'b1;
        t0 = cyc;
        wait_sig("t3_nlp1", W_NLP, 100);
        chk_eq("t3_first", cyc - t0, 40);
        tick();
        chk_eq("t3_width2", nlp, 1'b1);
        tick();
        chk_eq("t3_width_end", nlp, 1'b0);
        t1 = cyc - 2;
        wait_sig("t3_nlp2", W_NLP, 100);
        chk_eq("t3_period", cyc - t1, 42);
        link_en = 1'b0;
        tick();
        chk_eq("t3_completes", nlp, 1'b1);
        tick();
        chk_eq("t3_done", nlp, 1'b0);
        cnt_hi = 0;
        repeat (200) begin
            tick();
            if (nlp) cnt_hi++;
        end
        chk_eq("t3_off", cnt_hi, 0);
        link_en = 1'b1;
        t0 = cyc;
        wait_sig("t3_resume", W_NLP, 100);
        chk_eq("t3_hold", cyc - t0, 40);
        link_en = 1'b0;
        repeat (2) tick();

        // 4: busy never rises
        model_en = 1'b0;
        bus.req = 2'b01;
        wait_sig("t4_tx", W_TX, 10);
        t0 = cyc;
        wait_sig("t4_err", W_ERR, 20);
        chk_eq("t4_err_lat", cyc - t0, 4);
        t1 = cyc;
        tick();
        chk_eq("t4_err_1cyc", bus.err_timeout, 1'b0);
        wait_sig("t4_retx", W_TX, 30);
        chk_eq("t4_reserve", cyc - t1, 9);
        chk_eq("t4_grant", bus.grant, 2'b01);
        bus.req = 2'b00;
        wait_sig("t4_idle", W_IDLE, 40);
        model_en = 1'b1;

        // 5: request on the NLP expiry cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        link_en = 1'b1;
        repeat (39) tick();
        bus.req = 2'b01;
        tick();
        chk_eq("t5_tx", bus.transmit, 1'b1);
        chk_eq("t5_no_nlp", nlp, 1'b0);
        t0 = cyc;
        bus.req = 2'b00;
        wait_sig("t5_nlp", W_NLP, 120);
        chk_eq("t5_nlp_lat", cyc - t0, 70);
        link_en = 1'b0;
        repeat (2) tick();

        // 6: reset during SEND
        bus.req = 2'b01;
        wait_sig("t6_tx", W_TX, 10);
        bus.req = 2'b00;
        repeat (8) tick();
        chk_eq("t6_in_send", dut.state_q, ST_SEND);
        rst = 1'b1;
        tick();
        chk_eq("t6_rst_outs", outs(), 7'd0);
        chk_eq("t6_rst_state", dut.state_q, ST_IDLE);
        rst = 1'b0;
        tick();
        chk_eq("t6_rel_quiet", outs(), 7'd0);
        bus.req = 2'b10;
        tick();
        chk_eq("t6_tx", bus.transmit, 1'b1);
        chk_eq("t6_grant", bus.grant, 2'b10);
        chk_eq("t6_sel", bus.sel, 1'b1);
        bus.req = 2'b00;
        wait_sig("t6_fd", W_FD, 40);
        chk_eq("t6_sel_hold", bus.sel, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
